seq_frame_tx: RTL and testbench

Serial frame transmitter that drives a single-bit line with a fixed sync pattern `1001`, an MSB-first payload, an even-parity bit and a guard gap of zeros. It is the transmit end of the `1001` serial sync link: the existing `1001` detector watches this line and reports frame starts. A parallel source feeds payload words through a valid/ready handshake, one frame per accepted word.

---
 rtl/seq_link_pkg.sv | 22 ++
 rtl/seq_frame_tx_if.sv | 23 ++
 rtl/seq_frame_tx.sv | 120 ++++++++++++
 tb/tb_seq_frame_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_link_pkg.sv
// Shared definitions for the 1001 serial sync link: sync pattern, transmit
// state encoding and a sizing helper used by the transmitter.
package seq_link_pkg;

   localparam int SYNC_W = 4;
   localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1001;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_SYNC   = 5'b00010,
      ST_DATA   = 5'b00100,
      ST_PARITY = 5'b01000,
      ST_GAP    = 5'b10000
   } tx_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload handshake plus serial line and status for the frame transmitter.
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_data is only meaningful in that cycle, and in_valid may drop at will.
interface seq_frame_tx_if #(
   parameter int DATA_W = 8
) ();
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              d_out;
   logic              busy;
   logic              done;

   modport master (
      output in_valid, in_data,
      input  in_ready, d_out, busy, done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, d_out, busy, done
   );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync 1001, MSB-first payload, even parity,
// then GAP_CYCLES zero bits. One frame per accepted payload word.
module seq_frame_tx
   import seq_link_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rstn,
   seq_frame_tx_if.slave bus,
   output tx_state_t    state_o
);

   if (GAP_CYCLES < 1 || DATA_W < 1 || DATA_W > 32) begin : g_bad_param
      $error("seq_frame_tx: DATA_W must be 1..32 and GAP_CYCLES >= 1");
   end

   localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   tx_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              d_out_q, d_out_d;
   logic              done_q, done_d;
   logic [1:0]        sync_idx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         d_out_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         d_out_q <= d_out_d;
         done_q  <= done_d;
      end
   end

   // d_out_d is the bit the line carries in the cycle after this edge,
   // so every branch decides the next state's first or next bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      d_out_d  = 1'b0;
      done_d   = 1'b0;
      sync_idx = 2'(cnt_q - CNT_ONE);
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d = ST_SYNC;
               shift_d = bus.in_data;
               par_d   = ^bus.in_data;
               cnt_d   = SYNC_LOAD;
               d_out_d = SYNC_PAT[SYNC_W-1];
            end
         end
         ST_SYNC: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - CNT_ONE;
               d_out_d = SYNC_PAT[sync_idx];
            end else begin
               state_d = ST_DATA;
               cnt_d   = DATA_LOAD;
               d_out_d = shift_q[DATA_W-1];
               shift_d = shift_q << 1;
            end
         end
         ST_DATA: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - CNT_ONE;
               d_out_d = shift_q[DATA_W-1];
               shift_d = shift_q << 1;
            end else begin
               state_d = ST_PARITY;
               cnt_d   = '0;
               d_out_d = par_q;
            end
         end
         ST_PARITY: begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
         end
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
         end
      endcase
   end

   assign bus.in_ready = (state_q == ST_IDLE);
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.d_out    = d_out_q;
   assign bus.done     = done_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: a frame-level reference model fills expected
// queues at each handshake; a negedge monitor pops and compares.
module tb_seq_frame_tx;
   import seq_link_pkg::*;

   localparam int DW   = 8;
   localparam int GAP  = 2;
   localparam int DW2  = 4;
   localparam int GAP2 = 1;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   seq_frame_tx_if #(.DATA_W(DW))  bus1 ();
   seq_frame_tx_if #(.DATA_W(DW2)) bus2 ();
   tx_state_t state1, state2;

   seq_frame_tx #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .bus    (bus1),
      .state_o(state1)
   );

   seq_frame_tx #(.DATA_W(DW2), .GAP_CYCLES(GAP2)) dut2 (
      .clk    (clk),
      .rstn   (rstn),
      .bus    (bus2),
      .state_o(state2)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [0:0] exp_q[$];
   int start_q[$];
   int done_q[$];
   int det_exp_q[$];
   int det_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Reference frame: sync, payload MSB first, even parity by counting ones, gap zeros.
   task automatic push_frame(input logic [DW-1:0] d, input int t);
      logic [3:0] sp;
      int ones;
      sp = 4'b1001;
      ones = 0;
      for (int i = 3; i >= 0; i--) exp_q.push_back(sp[i]);
      for (int i = DW - 1; i >= 0; i--) begin
         exp_q.push_back(d[i]);
         if (d[i]) ones++;
      end
      exp_q.push_back(1'((ones % 2) != 0));
      for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
      start_q.push_back(t + 1);
      done_q.push_back(t + 6 + DW + GAP);
   endtask

   // ---------------- monitor (main DUT) ----------------
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      if (rstn) begin
         if (bus1.busy) begin
            if (!busy_prev) begin
               if (start_q.size() == 0) fail_now("unexpected_frame");
               else check("frame_start_cycle", cyc, start_q.pop_front());
            end
            if (exp_q.size() == 0) fail_now("extra_bit");
            else check("d_out_bit", bus1.d_out, exp_q.pop_front());
         end else begin
            check("idle_line_low", bus1.d_out, 0);
            if (busy_prev) begin
               check("frame_bits_left", exp_q.size(), 0);
               check("done_at_frame_end", bus1.done, 1);
            end
         end
         if (bus1.done) begin
            if (done_q.size() == 0) fail_now("unexpected_done");
            else check("done_cycle", cyc, done_q.pop_front());
         end
      end
      busy_prev <= bus1.busy;
   end

   // ---------------- loopback 1001 detector on second DUT ----------------
   logic [3:0] hist = 4'b0;
   always @(negedge clk) begin
      if (!rstn) begin
         hist <= 4'b0;
      end else begin
         hist <= {hist[2:0], bus2.d_out};
         if ({hist[2:0], bus2.d_out} == 4'b1001) begin
            det_cnt <= det_cnt + 1;
            if (det_exp_q.size() == 0) fail_now("loop_spurious_detect");
            else check("loop_detect_cycle", cyc, det_exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [DW-1:0] d, output int hs);
      int n;
      n = 0;
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.in_data  = d;
      while (!bus1.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus1.in_ready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: in_ready stayed 0, expected 1 (cycle %0d)", cyc);
         bus1.in_valid = 1'b0;
         hs = -1;
      end else begin
         hs = cyc;
         @(posedge clk);
         #1;
         push_frame(d, cyc - 1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((bus1.busy || exp_q.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_in_time", (n < 200), 1);
      repeat (2) @(posedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, t1;
      logic [DW-1:0] d;
      bus1.in_valid = 1'b0;
      bus1.in_data  = '0;
      bus2.in_valid = 1'b0;
      bus2.in_data  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_d_out", bus1.d_out, 0);
      check("rst_busy", bus1.busy, 0);
      check("rst_done", bus1.done, 0);
      check("rst_in_ready", bus1.in_ready, 1);
      check("rst_state", state1, ST_IDLE);
      #1 rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Basic frame A5
      send(8'hA5, t0);
      bus1.in_valid = 1'b0;
      drain();

      // Odd payload -> parity 1
      send(8'h01, t0);
      bus1.in_valid = 1'b0;
      drain();

      // Back-to-back with in_valid held high
      send(8'hFF, t0);
      send(8'h00, t1);
      bus1.in_valid = 1'b0;
      check("b2b_second_hs", t1 - t0, 16);
      drain();

      // Input activity mid-frame is ignored
      send(8'h3C, t0);
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         bus1.in_valid = 1'($urandom_range(0, 1));
         bus1.in_data  = DW'($urandom);
      end
      #1 bus1.in_valid = 1'b0;
      drain();

      // Mid-payload reset
      send(8'hC3, t0);
      bus1.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rstn = 1'b0;
      exp_q.delete();
      start_q.delete();
      done_q.delete();
      #1;
      check("midrst_d_out", bus1.d_out, 0);
      check("midrst_busy", bus1.busy, 0);
      check("midrst_in_ready", bus1.in_ready, 1);
      check("midrst_done", bus1.done, 0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      send(8'h96, t1);
      bus1.in_valid = 1'b0;
      check("midrst_new_hs", t1 - t0, 10);
      drain();

      // Randomized frames, sometimes back-to-back
      for (int k = 0; k < 20; k++) begin
         d = DW'($urandom);
         send(d, t0);
         if ($urandom_range(0, 1) == 0) begin
            bus1.in_valid = 1'b0;
            repeat ($urandom_range(0, 5)) @(posedge clk);
         end
      end
      bus1.in_valid = 1'b0;
      drain();
      check("left_start_q", start_q.size(), 0);
      check("left_done_q", done_q.size(), 0);

      // Loopback: three back-to-back 4'b0110 frames into a 1001 detector
      begin
         int hs, n;
         hs = 0;
         n = 0;
         @(negedge clk);
         bus2.in_valid = 1'b1;
         bus2.in_data  = 4'b0110;
         while (hs < 3 && n < 200) begin
            if (bus2.in_ready) begin
               hs++;
               det_exp_q.push_back(cyc + 4);
               if (hs == 3) begin
                  @(posedge clk);
                  #1 bus2.in_valid = 1'b0;
               end
            end
            if (hs < 3) begin
               @(negedge clk);
               n++;
            end
         end
         bus2.in_valid = 1'b0;
         check("loop_handshakes", hs, 3);
         repeat (30) @(posedge clk);
         check("loop_detections", det_cnt, 3);
         check("loop_pending", det_exp_q.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
